mac_feeder: RTL and testbench

- Producer side of the 3-lane fully-connected MAC stream in the VAD datapath.
- Collects the 108 2-bit binarised activations of one frame from the upstream layer, written one per cycle in index order.
- Replays them to the MAC as 36 beats of 3 lanes in the MAC's weight-index order.
- Ping-pong buffered, so frame N+1 is written while frame N streams.

---
 rtl/mac_feeder_pkg.sv | 30 +++
 rtl/feat_bank.sv | 32 +++
 rtl/mac_feeder.sv | 153 +++++++++++++++
 tb/tb_mac_feeder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_feeder_pkg.sv
// Shared VAD fully-connected stream definitions.
// Sizes, FSM encoding and the lane-index mirroring rule are shared by the
// feeder and the MAC so that both sides agree on the beat layout.
package mac_feeder_pkg;

    localparam int N_FEAT = 108;              // activations per frame
    localparam int LANES  = 3;                // activations per beat
    localparam int DW     = 2;                // activation width
    localparam int BEATS  = N_FEAT / LANES;   // beats per frame (36)

    localparam int IDX_W  = $clog2(N_FEAT);
    localparam int BEAT_W = $clog2(BEATS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_GAP    = 2'd2
    } feed_state_t;

    typedef logic [LANES-1:0][DW-1:0] lane_vec_t;

    // Lane 'lane' (0-based) at beat k reads index (lane+1)*BEATS-1-k: each
    // lane walks its third of the frame from the top down, which is the
    // order the MAC holds its weights in.
    function automatic logic [IDX_W-1:0] mirror_idx(input int lane,
                                                    input logic [BEAT_W-1:0] k);
        return IDX_W'((lane + 1) * BEATS - 1 - int'(k));
    endfunction

endpackage

// File: rtl/feat_bank.sv
// One activation bank: N_FEAT x DW storage with a single write port and a
// combinational LANES-wide read of the mirrored indices for beat rd_k.
// Ports:
//   clk    - clock
//   we     - write enable
//   waddr  - write index 0..N_FEAT-1
//   wdata  - activation to store
//   rd_k   - beat number selecting the three lane indices
//   lanes  - packed lane values for beat rd_k (lane 0 = feat_out1)
module feat_bank
    import mac_feeder_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DW-1:0]     wdata,
    input  logic [BEAT_W-1:0] rd_k,
    output lane_vec_t         lanes
);

    // Contents are don't-care after reset, so the array carries no reset.
    logic [DW-1:0] mem [N_FEAT];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign lanes[j] = mem[mirror_idx(j, rd_k)];
    end

endmodule

// File: rtl/mac_feeder.sv
// Producer side of the 3-lane FC MAC stream.
// Collects one frame of N_FEAT activations (one per cycle, index order) into
// a ping-pong bank and replays it as BEATS beats of LANES mirrored lanes.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   flush               - synchronous discard of both banks and the stream
//   wr_valid/wr_ready   - upstream activation handshake, wr_data payload
//   feat_out1..3        - lane values, zero whenever out_valid is low
//   out_valid, out_last - beat qualifier, high with the final beat
//   frame_done          - one-cycle pulse in the gap after the last beat
module mac_feeder
    import mac_feeder_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] feat_out1,
    output logic [DW-1:0] feat_out2,
    output logic [DW-1:0] feat_out3,
    output logic          out_valid,
    output logic          out_last,
    output logic          frame_done
);

    feed_state_t       state, state_nxt;
    logic [1:0]        bank_full, bank_full_nxt;
    logic              wr_bank, rd_bank;
    logic [IDX_W-1:0]  wr_idx;
    logic [BEAT_W-1:0] beat;
    logic [BEAT_W-1:0] rd_k;
    logic              wr_fire, wr_wrap;
    logic              load, retire;
    lane_vec_t         lane_q;
    lane_vec_t         bank_lanes [2];

    assign wr_ready = !bank_full[wr_bank] && !flush;
    assign wr_fire  = wr_valid && wr_ready;
    assign wr_wrap  = wr_fire && (wr_idx == IDX_W'(N_FEAT - 1));

    // In IDLE the first beat (k=0) is loaded; afterwards 'beat' already
    // holds the index of the next beat to present.
    assign rd_k = (state == ST_STREAM) ? beat : '0;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        localparam logic BSEL = 1'(b);
        feat_bank u_bank (
            .clk   (clk),
            .we    (wr_fire && (wr_bank == BSEL)),
            .waddr (wr_idx),
            .wdata (wr_data),
            .rd_k  (rd_k),
            .lanes (bank_lanes[b])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        retire    = 1'b0;
        if (flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bank_full[rd_bank]) begin
                        state_nxt = ST_STREAM;
                        load      = 1'b1;
                    end
                end
                ST_STREAM: begin
                    // out_last marks the beat now on the outputs; the edge
                    // that retires it leads into the gap cycle.
                    if (out_last) begin
                        state_nxt = ST_GAP;
                        retire    = 1'b1;
                    end else begin
                        load = 1'b1;
                    end
                end
                ST_GAP:  state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Fill of wr_bank and release of rd_bank may share an edge: they are
    // always different banks, since a full bank is never written.
    always_comb begin
        bank_full_nxt = bank_full;
        if (retire)  bank_full_nxt[rd_bank] = 1'b0;
        if (wr_wrap) bank_full_nxt[wr_bank] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_full  <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_idx     <= '0;
            beat       <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            lane_q     <= '0;
        end else if (flush) begin
            bank_full  <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_idx     <= '0;
            beat       <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            lane_q     <= '0;
        end else begin
            bank_full  <= bank_full_nxt;
            frame_done <= retire;
            if (retire) rd_bank <= ~rd_bank;

            if (wr_wrap) begin
                wr_idx  <= '0;
                wr_bank <= ~wr_bank;
            end else if (wr_fire) begin
                wr_idx  <= wr_idx + 1'b1;
            end

            if (load) begin
                out_valid <= 1'b1;
                out_last  <= (rd_k == BEAT_W'(BEATS - 1));
                lane_q    <= bank_lanes[rd_bank];
                beat      <= rd_k + 1'b1;
            end else begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                lane_q    <= '0;
                beat      <= '0;
            end
        end
    end

    assign feat_out1 = lane_q[0];
    assign feat_out2 = lane_q[1];
    assign feat_out3 = lane_q[2];

endmodule

// File: tb/tb_mac_feeder.sv
// Randomised bench for mac_feeder against a frame-level reference model.
// The model keeps two frame arrays, their full flags and a single "position
// in the output sequence" counter (0 idle, 1..BEATS showing beat t-1,
// BEATS+1 the done/gap cycle); expected lanes are looked up from the stored
// frame with the mirrored-index formula.
module tb_mac_feeder;
    import mac_feeder_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] feat_out1, feat_out2, feat_out3;
    logic          out_valid, out_last, frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    mac_feeder dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .feat_out1  (feat_out1),
        .feat_out2  (feat_out2),
        .feat_out3  (feat_out3),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem [2][N_FEAT];
    logic          m_full [2];
    int            m_wb, m_rb, m_widx, m_t;

    task automatic model_reset();
        m_full[0] = 1'b0;
        m_full[1] = 1'b0;
        m_wb = 0; m_rb = 0; m_widx = 0; m_t = 0;
    endtask

    function automatic logic m_ready(input logic f);
        return !m_full[m_wb] && !f;
    endfunction

    task automatic model_step(input logic v, input logic [DW-1:0] d, input logic f);
        logic rdy;
        if (f) begin
            model_reset();
            return;
        end
        rdy = m_ready(1'b0);
        if (m_t == 0) begin
            if (m_full[m_rb]) m_t = 1;
        end else if (m_t < BEATS) begin
            m_t++;
        end else if (m_t == BEATS) begin
            m_t = BEATS + 1;
            m_full[m_rb] = 1'b0;
            m_rb ^= 1;
        end else begin
            m_t = 0;
        end
        if (v && rdy) begin
            m_mem[m_wb][m_widx] = d;
            if (m_widx == N_FEAT - 1) begin
                m_full[m_wb] = 1'b1;
                m_widx = 0;
                m_wb ^= 1;
            end else begin
                m_widx++;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic ev;
        int   k;
        ev = (m_t >= 1) && (m_t <= BEATS);
        k  = m_t - 1;
        chk("out_valid", out_valid, ev);
        chk("out_last", out_last, m_t == BEATS);
        chk("frame_done", frame_done, m_t == BEATS + 1);
        if (ev) begin
            chk("lane1", feat_out1, m_mem[m_rb][BEATS - 1 - k]);
            chk("lane2", feat_out2, m_mem[m_rb][2 * BEATS - 1 - k]);
            chk("lane3", feat_out3, m_mem[m_rb][3 * BEATS - 1 - k]);
        end else begin
            chk("lane1_idle", feat_out1, 0);
            chk("lane2_idle", feat_out2, 0);
            chk("lane3_idle", feat_out3, 0);
        end
    endtask

    // Called at a falling edge: drive inputs, check wr_ready, advance the
    // model across the coming rising edge, then check outputs at the next
    // falling edge.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic f);
        wr_valid = v;
        wr_data  = d;
        flush    = f;
        #1;
        chk("wr_ready", wr_ready, m_ready(f));
        model_step(v, d, f);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0);
    endtask

    // Push n accepted activations, valid with probability pct%; data is held
    // while unaccepted, as the upstream layer does.
    task automatic push(input int n, input int pct);
        int            acc = 0;
        int            guard = 0;
        logic          v, take;
        logic [DW-1:0] d;
        d = DW'($urandom % 4);
        while (acc < n && guard < n * 6 + 200) begin
            v = (($urandom % 100) < pct) || (pct >= 100);
            take = v && m_ready(1'b0);
            cycle(v, d, 1'b0);
            if (take) begin
                acc++;
                d = DW'($urandom % 4);
            end
            guard++;
        end
        chk("accepted_count", acc, n);
    endtask

    task automatic do_reset();
        wr_valid = 1'b0;
        flush    = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_lanes", {feat_out1, feat_out2, feat_out3}, 0);
        chk("rst_wr_ready", wr_ready, 1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        model_reset();
        #2 rst = 1'b1;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_frame_done", frame_done, 0);
        chk("reset_lanes", {feat_out1, feat_out2, feat_out3}, 0);
        chk("reset_wr_ready", wr_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        check_outputs();

        // Directed frame a[i] = i % 4 with fixed expectations.
        for (int i = 0; i < N_FEAT; i++) cycle(1'b1, DW'(i % 4), 1'b0);
        chk("dir_pre_valid", out_valid, 0);
        cycle(1'b0, '0, 1'b0);
        chk("dir_b0_valid", out_valid, 1);
        chk("dir_b0_lanes", {feat_out1, feat_out2, feat_out3}, {2'd3, 2'd3, 2'd3});
        cycle(1'b0, '0, 1'b0);
        chk("dir_b1_lanes", {feat_out1, feat_out2, feat_out3}, {2'd2, 2'd2, 2'd2});
        chk("dir_b1_last", out_last, 0);
        idle(BEATS - 2);
        chk("dir_b35_last", out_last, 1);
        chk("dir_b35_lanes", {feat_out1, feat_out2, feat_out3}, 0);
        cycle(1'b0, '0, 1'b0);
        chk("dir_done", frame_done, 1);
        chk("dir_gap_valid", out_valid, 0);
        cycle(1'b0, '0, 1'b0);
        chk("dir_done_once", frame_done, 0);
        idle(5);

        // Back-to-back frames.
        push(2 * N_FEAT, 100);
        idle(90);
        push(3 * N_FEAT, 100);
        idle(90);

        // Flush on beat 17 with the other bank partly written.
        push(N_FEAT, 100);
        g = 0;
        while (m_t != 18 && g < 100) begin
            cycle(1'b1, DW'($urandom % 4), 1'b0);
            g++;
        end
        chk("flush_reached_beat17", m_t, 18);
        cycle(1'b1, DW'($urandom % 4), 1'b1);
        chk("flush_valid", out_valid, 0);
        chk("flush_no_done", frame_done, 0);
        push(N_FEAT, 100);
        idle(45);

        // Flush against the 108th write: the frame must not stream.
        push(N_FEAT - 1, 100);
        cycle(1'b1, DW'($urandom % 4), 1'b1);
        idle(5);
        chk("flush_108_no_stream", out_valid, 0);

        // Asynchronous reset mid-write and mid-stream.
        push(50, 100);
        do_reset();
        check_outputs();
        push(N_FEAT, 100);
        idle(10);
        do_reset();
        check_outputs();
        push(N_FEAT, 100);
        idle(45);

        // Random gaps inside frames.
        push(3 * N_FEAT, 60);
        idle(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
